// File: rtl/irq_ctrl_vec_if.sv
// Core-side bundle for the interrupt controller: raw requests, enables,
// mask write port, PC/return handshake, and the redirect/status outputs.
interface irq_ctrl_vec_if #(
   parameter int NUM_IRQ = 16
);
   localparam int ID_W = $clog2(NUM_IRQ);

   logic [NUM_IRQ-1:0] irq_i;
   logic               gie_i;
   logic               mask_we_i;
   logic [NUM_IRQ-1:0] mask_wdata_i;
   logic [31:0]        pc_i;
   logic               irq_done_i;
   logic               redirect_o;
   logic [31:0]        redirect_pc_o;
   logic               irq_active_o;
   logic [ID_W-1:0]    irq_id_o;
   logic [NUM_IRQ-1:0] pending_o;

   // core / bench side
   modport master (
      output irq_i, gie_i, mask_we_i, mask_wdata_i, pc_i, irq_done_i,
      input  redirect_o, redirect_pc_o, irq_active_o, irq_id_o, pending_o
   );

   // controller side
   modport slave (
      input  irq_i, gie_i, mask_we_i, mask_wdata_i, pc_i, irq_done_i,
      output redirect_o, redirect_pc_o, irq_active_o, irq_id_o, pending_o
   );
endinterface

// File: rtl/irq_ctrl_vec.sv
// Vectored/non-vectored interrupt controller with priority select, one
// handler in service at a time, and single-cycle PC redirect pulses.
// Optional macro IRQ_CTRL_VECTORED_EN: handler target = VEC_BASE + 4*id;
// otherwise every source enters at VEC_BASE and software reads irq_id_o.

// Per-source pending logic. Edge sources latch a rising edge until the
// handler for that source is entered; level sources track the sampled line.
module irq_src_cell #(
   parameter bit EDGE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   input  logic clr,
   output logic pend
);
   logic hist;

   // request history and pending bit; a new edge beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= 1'b0;
         pend <= 1'b0;
      end else begin
         hist <= irq;
         if (EDGE) pend <= (irq & ~hist) | (pend & ~clr);
         else      pend <= irq;
      end
   end
endmodule

module irq_ctrl_vec #(
   parameter int                 NUM_IRQ   = 16,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
   parameter logic [31:0]        VEC_BASE  = 32'h0000_0100
) (
   input logic            clk,
   input logic            rst_n,
   irq_ctrl_vec_if.slave  bus
);
   localparam int ID_W = $clog2(NUM_IRQ);

   typedef enum logic [1:0] {IDLE, ACTIVE, RETURN} state_t;

   // everything the FSM registers alongside its state
   typedef struct packed {
      logic            redirect;
      logic [31:0]     redirect_pc;
      logic            active;
      logic [ID_W-1:0] id;
      logic [31:0]     saved_pc;
   } ctl_t;

   state_t             state_q, state_d;
   ctl_t               ctl_q, ctl_d;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] cand;
   logic [NUM_IRQ-1:0] clr;
   logic [ID_W-1:0]    win;
   logic               any;
   logic               take;
   logic [31:0]        tgt;

   for (genvar k = 0; k < NUM_IRQ; k++) begin : g_src
      irq_src_cell #(.EDGE(EDGE_MASK[k])) u_src (
         .clk  (clk),
         .rst_n(rst_n),
         .irq  (bus.irq_i[k]),
         .clr  (clr[k]),
         .pend (pend[k])
      );
   end

   // enable mask; selection this cycle still sees the old value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             mask_q <= '1;
      else if (bus.mask_we_i) mask_q <= bus.mask_wdata_i;
   end

   // highest-index enabled pending source wins
   always_comb begin
      cand = pend & mask_q;
      any  = |cand;
      win  = '0;
      for (int k = 0; k < NUM_IRQ; k++)
         if (cand[k]) win = ID_W'(k);
   end

   // entry is only possible from IDLE; it clears the winner's edge latch
   always_comb begin
      take = (state_q == IDLE) && bus.gie_i && any;
      clr  = take ? (NUM_IRQ'(1) << win) : '0;
`ifdef IRQ_CTRL_VECTORED_EN
      tgt  = VEC_BASE + (32'(win) << 2);
`else
      tgt  = VEC_BASE;
`endif
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
      end
   end

   // next state; redirect defaults low so every redirect is one cycle wide
   always_comb begin
      state_d          = state_q;
      ctl_d            = ctl_q;
      ctl_d.redirect   = 1'b0;
      case (state_q)
         IDLE: begin
            if (take) begin
               state_d           = ACTIVE;
               ctl_d.redirect    = 1'b1;
               ctl_d.redirect_pc = tgt;
               ctl_d.active      = 1'b1;
               ctl_d.id          = win;
               ctl_d.saved_pc    = bus.pc_i + 32'd4;
            end
         end
         ACTIVE: begin
            if (bus.irq_done_i) begin
               state_d           = RETURN;
               ctl_d.redirect    = 1'b1;
               ctl_d.redirect_pc = ctl_q.saved_pc;
               ctl_d.active      = 1'b0;
            end
         end
         RETURN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.redirect_o    = ctl_q.redirect;
   assign bus.redirect_pc_o = ctl_q.redirect_pc;
   assign bus.irq_active_o  = ctl_q.active;
   assign bus.irq_id_o      = ctl_q.id;
   assign bus.pending_o     = pend;
endmodule

// File: tb/tb_irq_ctrl_vec.sv
// Bench for irq_ctrl_vec: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_irq_ctrl_vec;
   localparam int          N  = 16;
   localparam logic [N-1:0] EM = 16'h1004;
   localparam logic [31:0] VB = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst_n;

   irq_ctrl_vec_if #(.NUM_IRQ(N)) bus();

   irq_ctrl_vec #(.NUM_IRQ(N), .EDGE_MASK(EM), .VEC_BASE(VB)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // model state
   logic [N-1:0] m_pend, m_prev, m_mask;
   logic         m_redir, m_act, m_busy, m_ret;
   logic [31:0]  m_rpc, m_saved;
   int           m_id;

   function automatic logic [31:0] tgt(int id);
`ifdef IRQ_CTRL_VECTORED_EN
      return VB + 32'(id) * 4;
`else
      return VB;
`endif
   endfunction

   task automatic model_reset();
      m_pend = '0; m_prev = '0; m_mask = '1;
      m_redir = 0; m_act = 0; m_busy = 0; m_ret = 0;
      m_rpc = 0; m_saved = 0; m_id = 0;
   endtask

   // one clock edge of the controller's rules
   task automatic model_step();
      int win;
      logic take, fin;
      logic [N-1:0] np;
      if (!rst_n) begin model_reset(); return; end
      win = -1;
      for (int k = N - 1; k >= 0; k--)
         if (win < 0 && m_pend[k] && m_mask[k]) win = k;
      take = !m_busy && !m_ret && bus.gie_i && (win >= 0);
      fin  = m_busy && bus.irq_done_i;
      for (int k = 0; k < N; k++) begin
         if (EM[k]) np[k] = (bus.irq_i[k] && !m_prev[k]) || (m_pend[k] && !(take && k == win));
         else       np[k] = bus.irq_i[k];
      end
      m_pend  = np;
      m_prev  = bus.irq_i;
      if (bus.mask_we_i) m_mask = bus.mask_wdata_i;
      m_redir = take || fin;
      if (take) begin
         m_rpc = tgt(win); m_id = win; m_act = 1; m_saved = bus.pc_i + 32'd4; m_busy = 1;
      end else if (fin) begin
         m_rpc = m_saved; m_act = 0; m_busy = 0; m_ret = 1;
      end else begin
         m_ret = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      chk("redirect",    32'(bus.redirect_o),   32'(m_redir));
      chk("redirect_pc", bus.redirect_pc_o,     m_rpc);
      chk("active",      32'(bus.irq_active_o), 32'(m_act));
      chk("id",          32'(bus.irq_id_o),     32'(m_id));
      chk("pending",     32'(bus.pending_o),    32'(m_pend));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk); model_step();
         @(negedge clk); cmp_all();
      end
   endtask

   task automatic done_pulse();
      bus.irq_done_i = 1; cyc(1); bus.irq_done_i = 0;
   endtask

   initial begin
      rst_n = 0;
      bus.irq_i = '0; bus.gie_i = 0; bus.mask_we_i = 0; bus.mask_wdata_i = '0;
      bus.pc_i = '0; bus.irq_done_i = 0;
      model_reset();
      #1 cmp_all();
      @(negedge clk); rst_n = 1;

      // source 7 entry, return, one quiet RETURN cycle, then re-entry
      bus.irq_i = 16'h0080; bus.gie_i = 1; bus.pc_i = 32'h40;
      cyc(2);
      chk("e7_redirect", 32'(bus.redirect_o), 1);
      chk("e7_pc", bus.redirect_pc_o, tgt(7));
      chk("e7_id", 32'(bus.irq_id_o), 7);
      chk("e7_active", 32'(bus.irq_active_o), 1);
      cyc(1);
      chk("e7_pulse_end", 32'(bus.redirect_o), 0);
      done_pulse();
      chk("ret_redirect", 32'(bus.redirect_o), 1);
      chk("ret_pc", bus.redirect_pc_o, 32'h44);
      chk("ret_active", 32'(bus.irq_active_o), 0);
      cyc(1);
      chk("ret_no_reentry", 32'(bus.redirect_o), 0);
      cyc(1);
      chk("reentry", 32'(bus.redirect_o), 1);
      chk("reentry_id", 32'(bus.irq_id_o), 7);

      // priority, then masking source 11 away
      bus.irq_i = '0; done_pulse(); cyc(1);
      bus.irq_i = 16'h0808; cyc(2);
      chk("prio_id11", 32'(bus.irq_id_o), 11);
      bus.gie_i = 0; done_pulse(); cyc(1);
      bus.mask_we_i = 1; bus.mask_wdata_i = 16'hF7FF; cyc(1); bus.mask_we_i = 0;
      bus.gie_i = 1; cyc(1);
      chk("masked_id3", 32'(bus.irq_id_o), 3);
      chk("masked_redirect", 32'(bus.redirect_o), 1);
      bus.irq_i = '0; done_pulse();
      bus.mask_we_i = 1; bus.mask_wdata_i = '1; cyc(1); bus.mask_we_i = 0;

      // edge pulse on source 2 while source 5 is in service
      bus.irq_i = 16'h0020; cyc(2);
      chk("e5_id", 32'(bus.irq_id_o), 5);
      cyc(1);
      bus.irq_i = 16'h0024; cyc(1); bus.irq_i = 16'h0020; cyc(1);
      chk("edge2_latched", 32'(bus.pending_o[2]), 1);
      cyc(2);
      chk("edge2_held", 32'(bus.pending_o[2]), 1);
      chk("no_preempt", 32'(bus.irq_id_o), 5);
      bus.irq_i = '0; done_pulse(); cyc(1);
      chk("edge2_after_ret", 32'(bus.pending_o[2]), 1);
      cyc(1);
      chk("edge2_taken", 32'(bus.irq_id_o), 2);
      chk("edge2_cleared", 32'(bus.pending_o[2]), 0);
      done_pulse(); cyc(1);

      // gie off holds a pending source back
      bus.gie_i = 0; bus.irq_i = 16'h0200; cyc(1);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("gie0_pend9", 32'(bus.pending_o[9]), 1);
         chk("gie0_no_redirect", 32'(bus.redirect_o), 0);
      end
      bus.gie_i = 1; cyc(1);
      chk("e9_redirect", 32'(bus.redirect_o), 1);
      chk("e9_pc", bus.redirect_pc_o, tgt(9));
      chk("e9_id", 32'(bus.irq_id_o), 9);

      // return address wraps at 2^32
      bus.pc_i = 32'hFFFF_FFFC; done_pulse(); cyc(2);
      chk("wrap_entry", 32'(bus.redirect_o), 1);
      cyc(1); done_pulse();
      chk("wrap_ret_pc", bus.redirect_pc_o, 32'h0);
      cyc(2);
      chk("pre_rst_active", 32'(bus.irq_active_o), 1);

      // asynchronous reset in the middle of a handler
      #2 rst_n = 0; model_reset();
      #1 cmp_all();
      chk("rst_redirect_pc", bus.redirect_pc_o, 0);
      chk("rst_active", 32'(bus.irq_active_o), 0);
      bus.irq_i = '0; cyc(1);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("post_rst_quiet", 32'(bus.redirect_o), 0);
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) bus.irq_i = N'($urandom & $urandom & $urandom);
         bus.gie_i        = ($urandom_range(0, 7) != 0);
         bus.irq_done_i   = ($urandom_range(0, 3) == 0);
         bus.mask_we_i    = ($urandom_range(0, 15) == 0);
         bus.mask_wdata_i = N'($urandom | 32'h0000_F0F0);
         bus.pc_i         = $urandom & 32'hFFFF_FFFC;
         cyc(1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/irq_ctrl_vec.md
IRQ_CTRL_VEC -- requirements
Module: irq_ctrl_vec

Interface
REQ-001 Parameter NUM_IRQ, default 16; number of interrupt sources, range 2..32.
REQ-002 Parameter EDGE_MASK, width NUM_IRQ, default all 0; bit=1 makes that source edge-triggered (rising), bit=0 makes it level-triggered.
REQ-003 Parameter VEC_BASE, 32 bits, default 32'h00000100; handler base address.
REQ-004 Local ID_W = clog2(NUM_IRQ).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 irq_i  input  NUM_IRQ  raw interrupt requests; bit k is source k.
REQ-008 gie_i  input  1  global interrupt enable.
REQ-009 mask_we_i  input  1  write strobe for the enable-mask register.
REQ-010 mask_wdata_i  input  NUM_IRQ  new enable mask; bit=1 enables the source.
REQ-011 pc_i  input  32  PC of the instruction currently at the redirect point.
REQ-012 irq_done_i  input  1  handler-return strobe (mret retired).
REQ-013 redirect_o  output  1  one-cycle PC-redirect pulse.
REQ-014 redirect_pc_o  output  32  redirect target; valid while redirect_o=1.
REQ-015 irq_active_o  output  1  high while a handler is in service.
REQ-016 irq_id_o  output  ID_W  ID of the source in service.
REQ-017 pending_o  output  NUM_IRQ  current pending register.

Function
REQ-018 Pending bit, edge source: set on a 0->1 transition of irq_i[k] (one-cycle registered history); cleared on entry to that source's handler; set wins if both occur in the same cycle.
REQ-019 Pending bit, level source: equals registered irq_i[k]; not cleared by entry.
REQ-020 Candidate set = pending & mask; winner = highest-index candidate bit.
REQ-021 FSM states IDLE, ACTIVE, RETURN; reset state IDLE.
REQ-022 IDLE -> ACTIVE when gie_i=1 and candidate set non-zero; on that edge: saved_pc <= pc_i + 4, irq_id_o <= winner, irq_active_o <= 1, redirect_o <= 1, redirect_pc_o <= handler target.
REQ-023 ACTIVE: redirect_o=0; further requests stay pending with no preemption; irq_done_i=1 -> RETURN with redirect_o <= 1, redirect_pc_o <= saved_pc, irq_active_o <= 0.
REQ-024 RETURN: lasts exactly one cycle; redirect_o drops to 0; no entry taken; -> IDLE.
REQ-025 Redirect latency: redirect_o rises one cycle after the qualifying condition and is high for exactly one cycle.
REQ-026 irq_done_i in IDLE or RETURN: ignored.
REQ-027 Mask write: the mask register updates on the edge where mask_we_i=1; winner selection in that cycle uses the old mask; a write during ACTIVE does not affect the in-service source.
REQ-028 pc_i + 4: 32-bit add, wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-029 redirect_pc_o holds its last value when redirect_o=0.

Reset
REQ-030 On rst_n=0, immediately and independent of clk: state=IDLE, pending=0, edge history=0, mask=all 1, saved_pc=0, redirect_o=0, redirect_pc_o=0, irq_active_o=0, irq_id_o=0.
REQ-031 Reset during ACTIVE discards saved_pc and emits no return redirect.

Configuration
REQ-032 Macro IRQ_CTRL_VECTORED_EN defined: handler target = VEC_BASE + 4*winner (zero-extended ID).
REQ-033 Macro IRQ_CTRL_VECTORED_EN undefined: handler target = VEC_BASE for all sources; software reads irq_id_o to dispatch.

Verification (NUM_IRQ=16, VEC_BASE=0x100, EDGE_MASK=0)
REQ-034 Vectored build, irq_i[7]=1, gie_i=1, pc_i=0x40 -> one cycle later redirect_o=1, redirect_pc_o=0x11C, irq_id_o=7, irq_active_o=1.
REQ-035 Continuing REQ-034, irq_done_i pulse -> next cycle redirect_o=1, redirect_pc_o=0x44, irq_active_o=0; one RETURN cycle with no re-entry even though irq_i[7] is still high; re-entry follows.
REQ-036 irq_i[3] and irq_i[11] both high -> irq_id_o=11; with mask_wdata_i=0xF7FF written first -> irq_id_o=3.
REQ-037 Edge build (EDGE_MASK bit 2=1): 1-cycle pulse on irq_i[2] while ACTIVE on source 5 -> pending_o[2]=1 retained; taken after return, then pending_o[2]=0.
REQ-038 Non-vectored build, irq_i[9]=1 -> redirect_pc_o=0x100, irq_id_o=9; gie_i=0 -> no redirect while pending_o[9]=1.
REQ-039 rst_n asserted mid-ACTIVE -> all outputs zero in the same cycle; no redirect after release with irq_i=0.
